// File: rtl/waveform_gen_pkg.sv
// Shared constants for the waveform generator and the upstream mode-select FSM.
package waveform_gen_pkg;

  // Waveform mode encoding, shared with the mode-select FSM
  typedef enum logic [1:0] {
    ModeOff    = 2'd0,
    ModeSquare = 2'd1,
    ModeSaw    = 2'd2,
    ModeTri    = 2'd3
  } mode_e;

  localparam int unsigned WaveWidth = 8;   // phase / sample width
  localparam int unsigned DivWidth  = 16;  // clock divider width

endpackage

// File: rtl/waveform_gen_step_prescaler.sv
// Divides the system clock by a programmable divider, producing phase-advance strobes.
module step_prescaler
  import waveform_gen_pkg::*;
#(
  parameter int unsigned DIV_W = DivWidth
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic [DIV_W-1:0] divider,
  output logic             tick,
  output logic             step
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             terminal;

  // Terminal compare and next count; >= catches a divider lowered below the current count.
  // divider is nonzero whenever clear is low, so divider - 1 cannot underflow where it matters.
  always_comb begin
    terminal = (cnt_q >= (divider - DIV_W'(1)));
    tick     = ~clear & terminal;
    cnt_d    = cnt_q + DIV_W'(1);
    if (clear || terminal) begin
      cnt_d = '0;
    end
  end

  // Counter and registered step pulse
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
      step  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      step  <= tick;
    end
  end

endmodule

// File: rtl/waveform_gen.sv
// Phase accumulator plus shaper producing square / saw / triangle samples.
module waveform_gen
  import waveform_gen_pkg::*;
#(
  parameter int unsigned WIDTH = WaveWidth,
  parameter int unsigned DIV_W = DivWidth
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] divider,
  output logic [WIDTH-1:0] sample,
  output logic             step
);

  mode_e            mode_in;
  logic [1:0]       prev_mode_q;
  logic [WIDTH-1:0] phase_q, phase_d;
  logic [WIDTH-1:0] shaped, sample_d;
  logic [WIDTH-1:0] tri_d;
  logic             mode_change, silent, clear, tick;

  assign mode_in     = mode_e'(mode);
  assign mode_change = (mode != prev_mode_q);
  assign silent      = (mode_in == ModeOff) || (divider == '0);
  assign clear       = mode_change | silent;

  step_prescaler #(
    .DIV_W(DIV_W)
  ) u_prescaler (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (clear),
    .divider(divider),
    .tick   (tick),
    .step   (step)
  );

  // Shape the current phase; a mode change uses the new mode with the old phase
  always_comb begin
    shaped = '0;
    tri_d  = {phase_q[WIDTH-2:0], 1'b0};
    unique case (mode_in)
      ModeOff:    shaped = '0;
      ModeSquare: shaped = phase_q[WIDTH-1] ? '0 : '1;
      ModeSaw:    shaped = phase_q;
      ModeTri:    shaped = phase_q[WIDTH-1] ? ~tri_d : tri_d;
      default:    shaped = '0;
    endcase
  end

  // Next phase and sample
  always_comb begin
    phase_d  = phase_q;
    sample_d = silent ? '0 : shaped;
    if (clear) begin
      phase_d = '0;
    end else if (tick) begin
      phase_d = phase_q + WIDTH'(1);
    end
  end

  // Phase, mode history and sample registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      phase_q     <= '0;
      prev_mode_q <= 2'd0;
      sample      <= '0;
    end else begin
      phase_q     <= phase_d;
      prev_mode_q <= mode;
      sample      <= sample_d;
    end
  end

endmodule
